// File: rtl/user_io_spi_master.sv
// Host-side SPI master (mode 0) for the user_io / data_io link: command and payload bytes
// shifted MSB first, with a select held low across back-to-back bytes.
//
// state     | meaning
// S_IDLE    | no transaction, both selects high, waiting for cs_req & tx_valid
// S_SETUP   | select low, first data bit on SPI_DI, SCK low for CLKDIV cycles
// S_HIGH    | SCK high for CLKDIV cycles, SPI_DO sampled on entry
// S_LOW     | SCK low for CLKDIV cycles, next data bit on SPI_DI
// S_BYTE_DONE | byte finished, report rx byte, chain the next byte or wait
// S_GAP     | both selects high for CS_GAP cycles before returning to idle
module user_io_spi_master #(
   parameter int CLKDIV = 2,
   parameter int CS_GAP = 4
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       cs_req,
   input  logic       sel,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       SPI_SCK,
   output logic       SPI_DI,
   input  logic       SPI_DO,
   output logic       CONF_DATA0,
   output logic       SPI_SS2
);

   localparam int DMAX = (CLKDIV > CS_GAP) ? CLKDIV : CS_GAP;
   localparam int DW   = $clog2(DMAX + 1);
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLKDIV - 1);
   localparam logic [DW-1:0] GAP_LOAD = DW'(CS_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_BYTE_DONE,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      bit_q, bit_d;
   logic [6:0]      txsh_q, txsh_d;
   logic [7:0]      rxsh_q, rxsh_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            tx_ready_q, tx_ready_d;
   logic            busy_q, busy_d;
   logic            sck_q, sck_d;
   logic            di_q, di_d;
   logic            cs0_q, cs0_d;
   logic            ss2_q, ss2_d;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      txsh_d     = txsh_q;
      rxsh_d     = rxsh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_ready_d = 1'b0;
      sck_d      = sck_q;
      di_d       = di_q;
      cs0_d      = cs0_q;
      ss2_d      = ss2_q;

      case (state_q)
         S_IDLE: begin
            sck_d = 1'b0;
            if (cs_req && tx_valid) begin
               // The select choice is captured here and held until the gap.
               cs0_d      = sel;
               ss2_d      = !sel;
               txsh_d     = tx_data[6:0];
               di_d       = tx_data[7];
               tx_ready_d = 1'b1;
               bit_d      = 4'd0;
               div_d      = DIV_LOAD;
               state_d    = S_SETUP;
            end
         end

         S_SETUP, S_LOW: begin
            if (div_q == '0) begin
               sck_d   = 1'b1;
               rxsh_d  = {rxsh_q[6:0], SPI_DO};
               div_d   = DIV_LOAD;
               state_d = S_HIGH;
            end else begin
               div_d = div_q - DW'(1);
            end
         end

         S_HIGH: begin
            if (div_q == '0) begin
               sck_d = 1'b0;
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd7) begin
                  state_d = S_BYTE_DONE;
               end else begin
                  di_d    = txsh_q[6];
                  txsh_d  = {txsh_q[5:0], 1'b0};
                  div_d   = DIV_LOAD;
                  state_d = S_LOW;
               end
            end else begin
               div_d = div_q - DW'(1);
            end
         end

         S_BYTE_DONE: begin
            // bit_q still reads 8 only on the first cycle here, so the byte is reported once.
            if (bit_q == 4'd8) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rxsh_q;
               bit_d      = 4'd0;
            end
            if (cs_req && tx_valid) begin
               txsh_d     = tx_data[6:0];
               di_d       = tx_data[7];
               tx_ready_d = 1'b1;
               bit_d      = 4'd0;
               div_d      = DIV_LOAD;
               state_d    = S_SETUP;
            end else if (!cs_req) begin
               cs0_d   = 1'b1;
               ss2_d   = 1'b1;
               div_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (div_q == '0) begin
               state_d = S_IDLE;
            end else begin
               div_d = div_q - DW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= 4'd0;
         txsh_q     <= 7'd0;
         rxsh_q     <= 8'd0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         sck_q      <= 1'b0;
         di_q       <= 1'b0;
         cs0_q      <= 1'b1;
         ss2_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         txsh_q     <= txsh_d;
         rxsh_q     <= rxsh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         sck_q      <= sck_d;
         di_q       <= di_d;
         cs0_q      <= cs0_d;
         ss2_q      <= ss2_d;
      end
   end

   assign tx_ready   = tx_ready_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign busy       = busy_q;
   assign SPI_SCK    = sck_q;
   assign SPI_DI     = di_q;
   assign CONF_DATA0 = cs0_q;
   assign SPI_SS2    = ss2_q;

endmodule
